// File: rtl/host_csr_pkg.sv
// rtl/host_csr_pkg.sv - shared opcodes, FSM states and register map for the host CSR responder
package host_csr_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RESP  = 3'd3,
    ST_BLANK = 3'd4
  } csr_state_e;

  localparam int unsigned CTRL_ADDR = 32'h00;
  localparam int unsigned ECNT_ADDR = 32'h04;
  localparam int unsigned ARG_BASE  = 32'h08;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_DONE_BIT  = 1;

endpackage

// File: rtl/host_csr_regfile.sv
// rtl/host_csr_regfile.sv - CTRL/ECNT/ARG storage, write decode and read mux
// HOST_CSR_ECNT_EN adds the saturating launch-cycle counter behind ECNT.
module host_csr_regfile
  import host_csr_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32,
  parameter int NUM_ARGS  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [ADDR_BITS-1:0]          addr,
  input  logic [DATA_BITS-1:0]          wdata,
  input  logic                          finish,
  output logic [DATA_BITS-1:0]          rdata,
  output logic                          launch,
  output logic [NUM_ARGS*DATA_BITS-1:0] args
);

  logic                          start_q, start_d;
  logic                          done_q, done_d;
  logic [NUM_ARGS*DATA_BITS-1:0] args_q, args_d;
  logic [DATA_BITS-1:0]          ecnt_rd;

  logic                 aligned;
  logic                 ctrl_hit;
  logic                 arg_hit;
  logic [ADDR_BITS-1:0] arg_idx;
  logic                 ctrl_wr;
  logic                 ctrl_set;

  always_comb begin
    aligned  = (addr[1:0] == 2'b00);
    ctrl_hit = (addr == ADDR_BITS'(CTRL_ADDR));
    arg_idx  = (addr - ADDR_BITS'(ARG_BASE)) >> 2;
    arg_hit  = aligned && (addr >= ADDR_BITS'(ARG_BASE)) && (arg_idx < ADDR_BITS'(NUM_ARGS));
    ctrl_wr  = wr_en && ctrl_hit;
    ctrl_set = ctrl_wr && wdata[CTRL_START_BIT];
  end

  // Host write wins over finish for start; finish wins over the clear for done.
  always_comb begin
    start_d = ctrl_wr ? wdata[CTRL_START_BIT] : (finish ? 1'b0 : start_q);
    done_d  = finish | (done_q & ~ctrl_set);
    args_d  = args_q;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (wr_en && arg_hit && (arg_idx == ADDR_BITS'(i))) begin
        args_d[i*DATA_BITS +: DATA_BITS] = wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      args_q  <= '0;
    end else begin
      start_q <= start_d;
      done_q  <= done_d;
      args_q  <= args_d;
    end
  end

`ifdef HOST_CSR_ECNT_EN
  logic [DATA_BITS-1:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (ctrl_set) begin
      ecnt_d = '0;
    end else if (start_q && (ecnt_q != '1)) begin
      ecnt_d = ecnt_q + DATA_BITS'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign ecnt_rd = ecnt_q;
`else
  assign ecnt_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (ctrl_hit) begin
      rdata[CTRL_START_BIT] = start_q;
      rdata[CTRL_DONE_BIT]  = done_q;
    end else if (addr == ADDR_BITS'(ECNT_ADDR)) begin
      rdata = ecnt_rd;
    end else if (arg_hit) begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (arg_idx == ADDR_BITS'(i)) begin
          rdata = args_q[i*DATA_BITS +: DATA_BITS];
        end
      end
    end
  end

  assign launch = start_q;
  assign args   = args_q;

endmodule

// File: rtl/host_csr_responder.sv
// rtl/host_csr_responder.sv - host register request/response FSM around the CSR file
// Optional ECNT counter is enabled by defining HOST_CSR_ECNT_EN.
module host_csr_responder
  import host_csr_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32,
  parameter int NUM_ARGS  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_opcode,
  input  logic [ADDR_BITS-1:0]          req_addr,
  input  logic [DATA_BITS-1:0]          req_value,
  output logic                          req_deq,
  output logic                          resp_valid,
  output logic [DATA_BITS-1:0]          resp_bits,
  output logic                          launch,
  input  logic                          finish,
  output logic [NUM_ARGS*DATA_BITS-1:0] args
);

  csr_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] value_q, value_d;
  logic [DATA_BITS-1:0] resp_bits_q, resp_bits_d;
  logic [DATA_BITS-1:0] rdata;
  logic                 wr_en;

  // BLANK exists because the initiator drops req_valid one cycle after deq.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    value_d     = value_q;
    resp_bits_d = resp_bits_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          value_d = req_value;
          state_d = (req_opcode == OP_WRITE) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: state_d = ST_BLANK;
      ST_READ: begin
        resp_bits_d = rdata;
        state_d     = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_BLANK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      value_q     <= '0;
      resp_bits_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      value_q     <= value_d;
      resp_bits_q <= resp_bits_d;
    end
  end

  assign wr_en      = (state_q == ST_WRITE);
  assign req_deq    = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_bits  = resp_bits_q;

  host_csr_regfile #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS),
    .NUM_ARGS (NUM_ARGS)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .wr_en (wr_en),
    .addr  (addr_q),
    .wdata (value_q),
    .finish(finish),
    .rdata (rdata),
    .launch(launch),
    .args  (args)
  );

endmodule

// File: tb/tb_host_csr_responder.sv
// tb/tb_host_csr_responder.sv - directed self-checking bench for host_csr_responder
module tb_host_csr_responder;

  localparam int AB = 16;
  localparam int DB = 32;
  localparam int NA = 4;

  logic            clock;
  logic            reset;
  logic            req_valid;
  logic            req_opcode;
  logic [AB-1:0]   req_addr;
  logic [DB-1:0]   req_value;
  logic            req_deq;
  logic            resp_valid;
  logic [DB-1:0]   resp_bits;
  logic            launch;
  logic            finish;
  logic [NA*DB-1:0] args;

  int checks = 0;
  int errors = 0;

  host_csr_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_ARGS(NA)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_opcode(req_opcode),
    .req_addr  (req_addr),
    .req_value (req_value),
    .req_deq   (req_deq),
    .resp_valid(resp_valid),
    .resp_bits (resp_bits),
    .launch    (launch),
    .finish    (finish),
    .args      (args)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request; valid stays up through the cycle after deq, like the initiator.
  task automatic txn(input logic op, input logic [AB-1:0] a, input logic [DB-1:0] v,
                     input int fin_at, output logic [DB-1:0] rd, output int n_deq,
                     output int n_resp, output int deq_c, output int resp_c);
    n_deq = 0; n_resp = 0; deq_c = -1; resp_c = -1; rd = '0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_opcode = op; req_addr = a; req_value = v;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); #1;
      finish = (c == fin_at);
      if (req_deq) begin n_deq++; deq_c = c; end
      if (resp_valid) begin n_resp++; resp_c = c; rd = resp_bits; end
      if (c == 2) req_valid = 1'b0;
    end
    finish = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [AB-1:0] a, input logic [DB-1:0] v, input int fin_at);
    logic [DB-1:0] rd; int nd, nr, dc, rc;
    txn(1'b1, a, v, fin_at, rd, nd, nr, dc, rc);
    check({tag, " deq_count"}, nd, 1);
    check({tag, " deq_cycle"}, dc, 1);
    check({tag, " no_resp"}, nr, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [AB-1:0] a, input logic [DB-1:0] exp);
    logic [DB-1:0] rd; int nd, nr, dc, rc;
    txn(1'b0, a, '0, 0, rd, nd, nr, dc, rc);
    check({tag, " deq_count"}, nd, 1);
    check({tag, " deq_cycle"}, dc, 1);
    check({tag, " resp_count"}, nr, 1);
    check({tag, " resp_cycle"}, rc, 2);
    check({tag, " data"}, rd, exp);
    check({tag, " data_held"}, resp_bits, exp);
  endtask

  initial begin
    int n_resp, n_deq;
    reset = 1'b1; req_valid = 1'b0; req_opcode = 1'b0; req_addr = '0; req_value = '0; finish = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst req_deq", req_deq, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_bits", resp_bits, 0);
    check("rst launch", launch, 0);
    check("rst args", args, 0);
    reset = 1'b0;

    wr("wr_arg0", 16'h0008, 32'hDEADBEEF, 0);
    check("arg0 value", args[31:0], 32'hDEADBEEF);
    rd_chk("rd_arg0", 16'h0008, 32'hDEADBEEF);

    wr("wr_arg3", 16'h0014, 32'h12345678, 0);
    check("arg3 value", args[127:96], 32'h12345678);
    wr("wr_arg_oob", 16'h0018, 32'hAAAA5555, 0);
    check("arg oob ignored", args, {32'h12345678, 64'h0, 32'hDEADBEEF});
    rd_chk("rd_arg_oob", 16'h0018, 32'h0);

    rd_chk("rd_misaligned", 16'h0006, 32'h0);
    rd_chk("rd_unmapped", 16'h0100, 32'h0);
    wr("wr_unmapped", 16'h0100, 32'h0BADF00D, 0);
    wr("wr_misaligned", 16'h000A, 32'h0BADF00D, 0);
    check("args unchanged", args, {32'h12345678, 64'h0, 32'hDEADBEEF});

    // launch is high for 10 cycles, finish lands in the tenth
    wr("wr_ctrl_go", 16'h0000, 32'h1, 0);
    check("launch after start", launch, 1);
    repeat (7) @(posedge clock);
    #1; finish = 1'b1;
    @(posedge clock); #1; finish = 1'b0;
    check("launch after finish", launch, 0);
    rd_chk("rd_ctrl_done", 16'h0000, 32'h2);
`ifdef HOST_CSR_ECNT_EN
    rd_chk("rd_ecnt", 16'h0004, 32'd10);
`else
    rd_chk("rd_ecnt", 16'h0004, 32'd0);
`endif

    wr("wr_ctrl_restart", 16'h0000, 32'h1, 0);
    rd_chk("rd_ctrl_cleared", 16'h0000, 32'h1);
    wr("wr_ctrl_stop", 16'h0000, 32'h0, 0);
    check("launch stopped", launch, 0);
    @(posedge clock); #1; finish = 1'b1;
    @(posedge clock); #1; finish = 1'b0;
    rd_chk("rd_ctrl_idle_finish", 16'h0000, 32'h2);

    wr("wr_ctrl_race", 16'h0000, 32'h1, 1);
    check("launch race", launch, 1);
    rd_chk("rd_ctrl_race", 16'h0000, 32'h3);

    @(posedge clock); #1;
    req_valid = 1'b1; req_opcode = 1'b0; req_addr = 16'h0008;
    @(posedge clock); #1;
    check("abort in READ", req_deq, 1);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clock); #1;
    check("abort req_deq", req_deq, 0);
    check("abort resp_valid", resp_valid, 0);
    check("abort resp_bits", resp_bits, 0);
    check("abort launch", launch, 0);
    check("abort args", args, 0);
    reset = 1'b0;
    n_resp = 0; n_deq = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      if (resp_valid) n_resp++;
      if (req_deq) n_deq++;
    end
    check("abort no resp", n_resp, 0);
    check("abort no deq", n_deq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
